// File: rtl/nf10_reorder_pkg.sv
// ============================================================================
// nf10_reorder_pkg : shared types and constants for the reorder/merge block
// Revision: 1.0
// ============================================================================
`default_nettype none

package nf10_reorder_pkg;

  localparam int NUM_QUEUES = 5;
  localparam int QIDX_W     = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Width needed to hold 0..value-1, never less than one bit.
  function automatic int log2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < value) w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nf10_reorder_timeout.sv
// ============================================================================
// nf10_reorder_timeout : idle-cycle counter that pulses expire on its limit
// Revision: 1.0
// ============================================================================
`default_nettype none

module nf10_reorder_timeout
  import nf10_reorder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int               CNT_W = log2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    expire  = tick && !clear && (count_q == LIMIT);
    if (clear || expire) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/nf10_reorder_merge.sv
// ============================================================================
// nf10_reorder_merge : merges five AXI-Stream queues back into 0,1,2,3,4 order
// Optional queue-skip timeout enabled by macro NF10_REORDER_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nf10_reorder_merge
  import nf10_reorder_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
  input  logic                              s_axis_tvalid_0,
  input  logic                              s_axis_tlast_0,
  output logic                              s_axis_tready_0,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
  input  logic                              s_axis_tvalid_1,
  input  logic                              s_axis_tlast_1,
  output logic                              s_axis_tready_1,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_2,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
  input  logic                              s_axis_tvalid_2,
  input  logic                              s_axis_tlast_2,
  output logic                              s_axis_tready_2,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_3,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
  input  logic                              s_axis_tvalid_3,
  input  logic                              s_axis_tlast_3,
  output logic                              s_axis_tready_3,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_4,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb_4,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_4,
  input  logic                              s_axis_tvalid_4,
  input  logic                              s_axis_tlast_4,
  output logic                              s_axis_tready_4,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [15:0]                       skip_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  logic [DW-1:0]         s_tdata [NUM_QUEUES];
  logic [SW-1:0]         s_tstrb [NUM_QUEUES];
  logic [UW-1:0]         s_tuser [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] s_tvalid, s_tlast, s_tready;

  assign s_tdata  = '{s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2, s_axis_tdata_3, s_axis_tdata_4};
  assign s_tstrb  = '{s_axis_tstrb_0, s_axis_tstrb_1, s_axis_tstrb_2, s_axis_tstrb_3, s_axis_tstrb_4};
  assign s_tuser  = '{s_axis_tuser_0, s_axis_tuser_1, s_axis_tuser_2, s_axis_tuser_3, s_axis_tuser_4};
  assign s_tvalid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign s_tlast  = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
  assign {s_axis_tready_4, s_axis_tready_3, s_axis_tready_2, s_axis_tready_1, s_axis_tready_0} = s_tready;

  state_e              state_q, state_d;
  logic [QIDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [QIDX_W-1:0]   next_idx;
  logic                cur_valid;
  logic                expire;

  assign cur_valid = s_tvalid[cur_idx_q];
  assign next_idx  = (cur_idx_q == QIDX_W'(NUM_QUEUES - 1)) ? '0 : cur_idx_q + 1'b1;

  // Data fields follow the selected queue at all times; only the handshake is gated by state.
  always_comb begin
    state_d       = state_q;
    cur_idx_d     = cur_idx_q;
    s_tready      = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_tdata[cur_idx_q];
    m_axis_tstrb  = s_tstrb[cur_idx_q];
    m_axis_tuser  = s_tuser[cur_idx_q];
    m_axis_tlast  = s_tlast[cur_idx_q];
    case (state_q)
      ST_IDLE: begin
        if (cur_valid)   state_d   = ST_SEND;
        else if (expire) cur_idx_d = next_idx;
      end
      ST_SEND: begin
        m_axis_tvalid       = cur_valid;
        s_tready[cur_idx_q] = m_axis_tready;
        if (cur_valid && m_axis_tready && s_tlast[cur_idx_q]) begin
          state_d   = ST_IDLE;
          cur_idx_d = next_idx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= ST_IDLE;
      cur_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
    end
  end

`ifdef NF10_REORDER_TIMEOUT_EN
  logic [15:0] skip_q, skip_d;
  logic        to_tick, to_clear;

  // Count only while waiting on an empty selected queue; any SEND activity restarts it.
  assign to_tick  = (state_q == ST_IDLE) && !cur_valid;
  assign to_clear = (state_q == ST_SEND) || cur_valid;

  nf10_reorder_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (axi_aclk),
    .rst_n  (axi_resetn),
    .clear  (to_clear),
    .tick   (to_tick),
    .expire (expire)
  );

  always_comb begin
    skip_d = skip_q;
    if (expire && (skip_q != 16'hFFFF)) skip_d = skip_q + 16'd1;
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) skip_q <= '0;
    else             skip_q <= skip_d;
  end

  assign skip_count = skip_q;
`else
  assign expire     = 1'b0;
  assign skip_count = '0;
`endif

endmodule

`default_nettype wire
